// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding request, a single-entry output
// register to the controller, branch redirect with response kill.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PCSrc,
  input  logic [31:0]      BranchTarget,
  output logic             IMemReq,
  output logic [31:0]      IMemAddr,
  input  logic             IMemValid,
  input  logic [31:0]      IMemData,
  output logic [31:0]      Instruction,
  output logic [31:0]      InstrPC,
  output logic             InstrValid,
  input  logic             InstrReady,
  output logic [CNT_W-1:0] FetchCount,
  output logic             Debug
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic             kill, kill_nxt;
  logic [31:0]      instr, instr_nxt;
  logic [31:0]      instr_pc, instr_pc_nxt;
  logic             instr_vld, instr_vld_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             debug, debug_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    kill_nxt      = kill;
    instr_nxt     = instr;
    instr_pc_nxt  = instr_pc;
    instr_vld_nxt = instr_vld;
    cnt_nxt       = cnt;
    // A response is only legal while waiting for one.
    debug_nxt     = debug | (IMemValid && (state != S_WAIT));

    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        state_nxt = S_WAIT;
        if (PCSrc) kill_nxt = 1'b1;
      end
      S_WAIT: begin
        if (IMemValid) begin
          if (kill || PCSrc) begin
            kill_nxt  = 1'b0;
            state_nxt = S_FETCH;
          end else begin
            instr_nxt     = IMemData;
            instr_pc_nxt  = pc;
            instr_vld_nxt = 1'b1;
            pc_nxt        = pc + 32'd4;
            state_nxt     = S_OUT;
          end
        end else if (PCSrc) begin
          kill_nxt = 1'b1;
        end
      end
      S_OUT: begin
        // A redirect squashes the held instruction without counting it.
        if (PCSrc) begin
          instr_vld_nxt = 1'b0;
          state_nxt     = S_FETCH;
        end else if (InstrReady) begin
          instr_vld_nxt = 1'b0;
          cnt_nxt       = sat_inc(cnt);
          state_nxt     = S_FETCH;
        end
      end
      default: state_nxt = S_RESET;
    endcase

    if (PCSrc) pc_nxt = align_word(BranchTarget);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc        <= RESET_PC;
      kill      <= 1'b0;
      instr     <= 32'h00000000;
      instr_pc  <= 32'h00000000;
      instr_vld <= 1'b0;
      cnt       <= '0;
      debug     <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      kill      <= kill_nxt;
      instr     <= instr_nxt;
      instr_pc  <= instr_pc_nxt;
      instr_vld <= instr_vld_nxt;
      cnt       <= cnt_nxt;
      debug     <= debug_nxt;
    end
  end

  assign IMemReq     = (state == S_FETCH);
  assign IMemAddr    = pc;
  assign Instruction = instr;
  assign InstrPC     = instr_pc;
  assign InstrValid  = instr_vld;
  assign FetchCount  = cnt;
  assign Debug       = debug;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed protocol scenarios followed by a
// randomized run checked against a transaction-level fetch model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam int          CNT_W    = 4;
  localparam int          CMAX     = (1 << CNT_W) - 1;

  logic             Clk;
  logic             Rst;
  logic             PCSrc;
  logic [31:0]      BranchTarget;
  logic             IMemReq;
  logic [31:0]      IMemAddr;
  logic             IMemValid;
  logic [31:0]      IMemData;
  logic [31:0]      Instruction;
  logic [31:0]      InstrPC;
  logic             InstrValid;
  logic             InstrReady;
  logic [CNT_W-1:0] FetchCount;
  logic             Debug;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemValid(IMemValid),
    .IMemData(IMemData), .Instruction(Instruction), .InstrPC(InstrPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .FetchCount(FetchCount), .Debug(Debug)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_req"},   32'(IMemReq),    32'd0);
    chk({tag, "_addr"},  IMemAddr,        RESET_PC);
    chk({tag, "_instr"}, Instruction,     32'd0);
    chk({tag, "_ipc"},   InstrPC,         32'd0);
    chk({tag, "_vld"},   32'(InstrValid), 32'd0);
    chk({tag, "_cnt"},   32'(FetchCount), 32'd0);
    chk({tag, "_dbg"},   32'(Debug),      32'd0);
  endtask

  // Memory contents are an address-derived pattern.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  // Transaction-level model state for the randomized run.
  logic        exp_req, exp_vld, n_req, n_vld;
  logic [31:0] exp_addr, exp_ipc, exp_instr, req_addr, tgt;
  int          exp_cnt;
  logic        outstanding, live, pcsrc_r, ready_r, valid_r;
  int          due;

  initial begin
    Rst = 1'b1; PCSrc = 1'b0; BranchTarget = '0; IMemValid = 1'b0;
    IMemData = '0; InstrReady = 1'b0;
    repeat (3) tick();
    chk_rst("rst_hold");

    PCSrc = 1'b1; BranchTarget = 32'h00001234; IMemValid = 1'b1;
    IMemData = 32'hDEADBEEF; InstrReady = 1'b1;
    repeat (2) tick();
    chk_rst("rst_inputs_ignored");
    PCSrc = 1'b0; IMemValid = 1'b0;

    // Reset release and first fetch
    Rst = 1'b0;
    #1 chk("c0_no_req", 32'(IMemReq), 32'd0);
    tick();
    chk("c1_req", 32'(IMemReq), 32'd1);
    chk("c1_addr", IMemAddr, 32'h00000000);
    tick();
    chk("c2_no_req", 32'(IMemReq), 32'd0);
    IMemValid = 1'b1; IMemData = 32'h8C010004;
    tick();
    IMemValid = 1'b0;
    chk("c3_vld", 32'(InstrValid), 32'd1);
    chk("c3_instr", Instruction, 32'h8C010004);
    chk("c3_ipc", InstrPC, 32'h00000000);
    chk("c3_cnt", 32'(FetchCount), 32'd0);
    tick();
    chk("c4_vld", 32'(InstrValid), 32'd0);
    chk("c4_cnt", 32'(FetchCount), 32'd1);
    chk("c4_req", 32'(IMemReq), 32'd1);
    chk("c4_addr", IMemAddr, 32'h00000004);

    // Back-pressure: instruction held while InstrReady is low
    InstrReady = 1'b0;
    tick();
    IMemValid = 1'b1; IMemData = 32'h11112222;
    tick();
    IMemValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", 32'(InstrValid), 32'd1);
      chk("hold_instr", Instruction, 32'h11112222);
      chk("hold_ipc", InstrPC, 32'h00000004);
      chk("hold_no_req", 32'(IMemReq), 32'd0);
      chk("hold_cnt", 32'(FetchCount), 32'd1);
      tick();
    end
    InstrReady = 1'b1;
    tick();
    chk("hold_rel_vld", 32'(InstrValid), 32'd0);
    chk("hold_rel_cnt", 32'(FetchCount), 32'd2);
    chk("hold_rel_addr", IMemAddr, 32'h00000008);

    // Redirect while waiting: late response dropped, refetch aligned target
    tick();
    PCSrc = 1'b1; BranchTarget = 32'h00000043;
    tick();
    PCSrc = 1'b0; IMemValid = 1'b1; IMemData = 32'hBAD0BAD0;
    chk("kill_wait_no_req", 32'(IMemReq), 32'd0);
    tick();
    IMemValid = 1'b0;
    chk("kill_vld", 32'(InstrValid), 32'd0);
    chk("kill_req", 32'(IMemReq), 32'd1);
    chk("kill_addr", IMemAddr, 32'h00000040);
    chk("kill_dbg", 32'(Debug), 32'd0);

    // Redirect and ready together in OUT: squash, no count
    tick();
    IMemValid = 1'b1; IMemData = 32'h33334444;
    tick();
    IMemValid = 1'b0;
    chk("out_vld", 32'(InstrValid), 32'd1);
    chk("out_ipc", InstrPC, 32'h00000040);
    chk("out_instr", Instruction, 32'h33334444);
    PCSrc = 1'b1; BranchTarget = 32'h00000100;
    tick();
    PCSrc = 1'b0;
    chk("outredir_vld", 32'(InstrValid), 32'd0);
    chk("outredir_cnt", 32'(FetchCount), 32'd2);
    chk("outredir_req", 32'(IMemReq), 32'd1);
    chk("outredir_addr", IMemAddr, 32'h00000100);

    // Redirect in FETCH to the top word, then wrap to zero
    PCSrc = 1'b1; BranchTarget = 32'hFFFFFFFF;
    tick();
    PCSrc = 1'b0; IMemValid = 1'b1; IMemData = 32'hBAD1BAD1;
    tick();
    IMemValid = 1'b0;
    chk("top_req", 32'(IMemReq), 32'd1);
    chk("top_addr", IMemAddr, 32'hFFFFFFFC);
    chk("top_vld", 32'(InstrValid), 32'd0);
    tick();
    IMemValid = 1'b1; IMemData = 32'h55556666;
    tick();
    IMemValid = 1'b0;
    chk("top_ovld", 32'(InstrValid), 32'd1);
    chk("top_ipc", InstrPC, 32'hFFFFFFFC);
    chk("top_instr", Instruction, 32'h55556666);
    tick();
    chk("wrap_addr", IMemAddr, 32'h00000000);
    chk("wrap_cnt", 32'(FetchCount), 32'd3);
    chk("wrap_dbg0", 32'(Debug), 32'd0);

    // Spurious response during FETCH sets the sticky flag
    IMemValid = 1'b1; IMemData = 32'hBAD2BAD2;
    tick();
    chk("spur_dbg", 32'(Debug), 32'd1);
    chk("spur_vld", 32'(InstrValid), 32'd0);
    IMemData = 32'h77778888;
    tick();
    IMemValid = 1'b0;
    chk("spur_ovld", 32'(InstrValid), 32'd1);
    chk("spur_instr", Instruction, 32'h77778888);
    chk("spur_ipc", InstrPC, 32'h00000000);
    chk("spur_dbg_hold", 32'(Debug), 32'd1);
    tick();
    chk("spur_next_addr", IMemAddr, 32'h00000004);
    chk("spur_cnt", 32'(FetchCount), 32'd4);
    chk("spur_dbg_hold2", 32'(Debug), 32'd1);

    // Reset mid-request, stale response returned during RESET
    tick();
    Rst = 1'b1;
    #1 chk_rst("rst_mid_wait");
    tick();
    Rst = 1'b0; IMemValid = 1'b1; IMemData = 32'hBAD3BAD3;
    tick();
    IMemValid = 1'b0;
    chk("stale_dbg", 32'(Debug), 32'd1);
    chk("stale_req", 32'(IMemReq), 32'd1);
    chk("stale_addr", IMemAddr, RESET_PC);
    chk("stale_vld", 32'(InstrValid), 32'd0);
    chk("stale_instr", Instruction, 32'd0);
    chk("stale_ipc", InstrPC, 32'd0);
    chk("stale_cnt", 32'(FetchCount), 32'd0);

    // Fresh reset with a redirect in RESET, then randomized traffic
    Rst = 1'b1;
    tick();
    Rst = 1'b0; PCSrc = 1'b1; BranchTarget = 32'h00000203; InstrReady = 1'b0;
    exp_req = 1'b1; exp_vld = 1'b0; exp_addr = 32'h00000200; exp_cnt = 0;
    exp_ipc = '0; exp_instr = '0; req_addr = '0;
    outstanding = 1'b0; live = 1'b0; due = 0;

    for (int c = 0; c < 1500; c++) begin
      tick();
      chk("rnd_req", 32'(IMemReq), 32'(exp_req));
      if (exp_req) chk("rnd_addr", IMemAddr, exp_addr);
      chk("rnd_vld", 32'(InstrValid), 32'(exp_vld));
      if (exp_vld) begin
        chk("rnd_instr", Instruction, exp_instr);
        chk("rnd_ipc", InstrPC, exp_ipc);
      end
      chk("rnd_cnt", 32'(FetchCount), 32'(exp_cnt));
      chk("rnd_dbg", 32'(Debug), 32'd0);

      pcsrc_r = ($urandom_range(0, 7) == 0);
      tgt     = $urandom();
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF0 | (tgt & 32'h0000000F);
      ready_r = ($urandom_range(0, 2) != 0);
      valid_r = outstanding && (c == due);
      PCSrc        = pcsrc_r;
      BranchTarget = tgt;
      InstrReady   = ready_r;
      IMemValid    = valid_r;
      IMemData     = valid_r ? memfn(req_addr) : $urandom();

      n_req = 1'b0;
      n_vld = exp_vld;
      if (exp_vld) begin
        if (pcsrc_r) begin
          n_vld = 1'b0; n_req = 1'b1;
        end else if (ready_r) begin
          n_vld = 1'b0; n_req = 1'b1;
          exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
        end
      end
      if (exp_req) begin
        outstanding = 1'b1; live = 1'b1; req_addr = exp_addr;
        due = c + int'($urandom_range(1, 3));
      end
      if (valid_r) begin
        outstanding = 1'b0;
        if (live && !pcsrc_r) begin
          n_vld = 1'b1; exp_ipc = req_addr; exp_instr = memfn(req_addr);
          exp_addr = req_addr + 32'd4;
        end else begin
          n_req = 1'b1;
        end
      end
      if (pcsrc_r) begin
        live = 1'b0;
        exp_addr = tgt & 32'hFFFFFFFC;
      end
      exp_req = n_req;
      exp_vld = n_vld;
    end

    PCSrc = 1'b0; IMemValid = 1'b0; InstrReady = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the delivered-instruction counter.
REQ-003 SHALL have port Clk  input  1  system clock, all state updates on the rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port PCSrc  input  1  redirect strobe from the controller (taken branch).
REQ-006 SHALL have port BranchTarget  input  32  redirect address, sampled when PCSrc=1.
REQ-007 SHALL have port IMemReq  output  1  instruction memory read request, one-cycle pulse.
REQ-008 SHALL have port IMemAddr  output  32  word-aligned read address, valid while IMemReq=1.
REQ-009 SHALL have port IMemValid  input  1  read data valid, arrives 1 or more cycles after IMemReq.
REQ-010 SHALL have port IMemData  input  32  read data, valid while IMemValid=1.
REQ-011 SHALL have port Instruction  output  32  instruction to the controller.
REQ-012 SHALL have port InstrPC  output  32  address of Instruction.
REQ-013 SHALL have port InstrValid  output  1  Instruction holds a live instruction.
REQ-014 SHALL have port InstrReady  input  1  the controller accepts Instruction this cycle.
REQ-015 SHALL have port FetchCount  output  CNT_W  number of instructions accepted, saturating.
REQ-016 SHALL have port Debug  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL implement the states RESET, FETCH, WAIT and OUT, with at most one memory request outstanding.
REQ-018 RESET SHALL last one cycle after Rst deasserts and then move to FETCH.
REQ-019 In FETCH, IMemReq SHALL be 1 and IMemAddr SHALL equal PC, and the next state SHALL be WAIT.
REQ-020 In WAIT, with IMemValid=1 and Kill=0: latch Instruction<=IMemData and InstrPC<=PC; set InstrValid=1; PC<=PC+4; go to OUT.
REQ-021 In OUT, with InstrValid=1, Instruction and InstrPC SHALL hold stable until InstrReady=1.
REQ-022 In OUT, when InstrReady=1, InstrValid SHALL clear on the next edge, FetchCount SHALL increment, and the next state SHALL be FETCH.
REQ-023 Throughput SHALL be one instruction per 3 cycles with a 1-cycle memory and InstrReady tied high.
REQ-024 When PCSrc=1 in any state other than RESET, PC SHALL become {BranchTarget[31:2],2'b00} on the next edge, with the low 2 bits forced to zero.
REQ-025 A redirect in FETCH or WAIT SHALL set Kill; the response that arrives with Kill=1 SHALL be discarded, Kill SHALL clear, and the next state SHALL be FETCH.
REQ-026 A redirect in OUT SHALL clear InstrValid on the next edge and move to FETCH; FetchCount SHALL NOT increment, even if InstrReady=1 in the same cycle.
REQ-027 A redirect in RESET SHALL load the PC and still proceed to FETCH.
REQ-028 Simultaneous PCSrc=1 and IMemValid=1 in WAIT: the response SHALL be discarded, the redirect PC applied, and the next state SHALL be FETCH.
REQ-029 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 SHALL give 32'h00000000.
REQ-030 FetchCount SHALL saturate at 2^CNT_W-1.
REQ-031 IMemValid=1 outside WAIT SHALL be ignored as data and SHALL set Debug, which holds until reset.

Reset
REQ-032 Rst=1 SHALL immediately force the following values: state=RESET; PC=RESET_PC; IMemReq=0; IMemAddr=RESET_PC; Instruction=32'h00000000; InstrPC=0; InstrValid=0; Kill=0; FetchCount=0; Debug=0.
REQ-033 Rst asserted mid-request SHALL abandon the outstanding request; a response arriving after reset, while in RESET, SHALL set Debug.
REQ-034 Outputs SHALL not change during Rst=1, regardless of other inputs.

Verification
REQ-035 Reset release, 1-cycle memory returning 32'h8C010004, InstrReady=1: IMemReq in cycle 1 with IMemAddr=0; InstrValid in cycle 3 with Instruction=32'h8C010004 and InstrPC=0; the next IMemAddr=4.
REQ-036 InstrReady=0 for 5 cycles while in OUT: Instruction, InstrPC and InstrValid are stable for all 5 cycles, no IMemReq, and FetchCount is unchanged.
REQ-037 PCSrc=1 with BranchTarget=32'h00000043 in WAIT, then a response: the response is dropped and the next IMemAddr=32'h00000040.
REQ-038 PCSrc=1 and InstrReady=1 together in OUT: InstrValid=0 on the next edge, FetchCount unchanged, the next IMemAddr equals the target.
REQ-039 PC=32'hFFFFFFFC fetch accepted: the next IMemAddr=0. IMemValid pulsed in FETCH: Debug=1 and stays 1 until Rst.
REQ-040 Rst pulsed while in WAIT, with the stale response returned in RESET: all outputs are at reset values, Debug=1, and the first fetch is from RESET_PC.
